// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scan logic.
package display_pkg;
  localparam int         DIGIT_W = 4;
  localparam logic [3:0] MAX_BCD = 4'd9;

  typedef enum logic {BLANK, SHOW} scan_state_t;
  typedef logic [DIGIT_W-1:0] bcd_t;
endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Free-running slot counter for the display scan.
// Flags the last blanking cycle and the last cycle of each digit slot.
module scan_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          blank_end,
  output logic          slot_end
);

  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
  // With no blanking the guard period is over before it starts.
  assign blank_end = (BLANK_CYCLES == 0) ? 1'b1 : (cnt == CW'(BLANK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (slot_end)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_scan_controller.sv
// Scans N BCD digits onto one shared 7-segment decoder, with blanking guard,
// frame-synchronous digit updates, leading-zero suppression and invalid-code flagging.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 2,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic                        load,
  input  logic                        lz_en,
  output bcd_t                        digit_code,
  output logic [N_DIGITS-1:0]         anode,
  output logic                        frame_done,
  output logic                        code_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] ANODE_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [CW-1:0]               cnt;
  logic                        blank_end, slot_end, wrap;
  logic                        unused_cnt;
  scan_state_t                 state, state_n;
  logic [IW-1:0]               idx, idx_n;
  logic [N_DIGITS*DIGIT_W-1:0] active, active_n, pending;
  logic                        pending_vld;
  bcd_t                        cur, code_n;
  logic                        bad, upper_zero, suppress;
  logic [N_DIGITS-1:0]         anode_on, anode_n;

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .blank_end(blank_end),
    .slot_end (slot_end)
  );

  assign unused_cnt = ^cnt;
  assign wrap       = slot_end && (idx == IW'(N_DIGITS - 1));

  // Outputs are derived from next-cycle state so the registered pins line up with it.
  always_comb begin
    state_n = state;
    case (state)
      BLANK: if (blank_end) state_n = SHOW;
      SHOW:  if (slot_end)  state_n = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      default: state_n = BLANK;
    endcase

    idx_n = idx;
    if (slot_end)
      idx_n = wrap ? '0 : idx + 1'b1;

    active_n = (wrap && pending_vld) ? pending : active;

    cur = active_n[idx_n*DIGIT_W +: DIGIT_W];
    bad = (cur > MAX_BCD);

    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++)
      if (i >= int'(idx_n) && active_n[i*DIGIT_W +: DIGIT_W] != '0)
        upper_zero = 1'b0;

    suppress = bad || (lz_en && (idx_n != '0) && upper_zero);
    code_n   = bad ? '0 : cur;

    anode_on = '0;
    if (state_n == SHOW && !suppress)
      anode_on[idx_n] = 1'b1;
    anode_n = AN_ACTIVE_LOW ? ~anode_on : anode_on;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      idx         <= '0;
      active      <= '0;
      pending     <= '0;
      pending_vld <= 1'b0;
      digit_code  <= '0;
      anode       <= ANODE_OFF;
      frame_done  <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      active <= active_n;
      // A load on the wrap edge refills the shadow after the old value moved to active.
      if (load) begin
        pending     <= digits_in;
        pending_vld <= 1'b1;
      end else if (wrap) begin
        pending_vld <= 1'b0;
      end
      digit_code <= code_n;
      anode      <= anode_n;
      frame_done <= wrap;
      code_err   <= code_err | bad;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a short 8-cycle slot.
module tb_display_scan_controller;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  digit_code;
  logic [3:0]  anode;
  logic        frame_done;
  logic        code_err;

  int checks = 0;
  int errors = 0;

  display_scan_controller #(
    .N_DIGITS     (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .lz_en     (lz_en),
    .digit_code(digit_code),
    .anode     (anode),
    .frame_done(frame_done),
    .code_err  (code_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0]     digits;
    logic            lz;
    logic [3:0][3:0] codes;
    logic [3:0][3:0] ans;
  } vec_t;

  vec_t vecs[5];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] ea, input logic [3:0] ec,
                       input logic efd, input logic eerr);
    checks++;
    if (anode !== ea || digit_code !== ec || frame_done !== efd || code_err !== eerr) begin
      errors++;
      $display("[TB] FAIL %s: got anode=%b code=%0d fd=%b err=%b, expected anode=%b code=%0d fd=%b err=%b",
               name, anode, digit_code, frame_done, code_err, ea, ec, efd, eerr);
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 40; i++) begin
      if (frame_done === 1'b1) return;
      step(1);
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_frame: frame_done=%b after 40 cycles, expected 1", frame_done);
  endtask

  task automatic do_load(input logic [15:0] d);
    digits_in = d;
    load      = 1'b1;
    step(1);
    load      = 1'b0;
  endtask

  task automatic load_and_sync(input logic [15:0] d);
    wait_frame();
    step(1);
    do_load(d);
    wait_frame();
  endtask

  initial begin
    vecs[0] = '{digits:16'h1234, lz:1'b0, codes:{4'd1, 4'd2, 4'd3, 4'd4},
                ans:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = '{digits:16'h0070, lz:1'b1, codes:{4'd0, 4'd0, 4'd7, 4'd0},
                ans:{4'b1111, 4'b1111, 4'b1101, 4'b1110}};
    vecs[2] = '{digits:16'h0070, lz:1'b0, codes:{4'd0, 4'd0, 4'd7, 4'd0},
                ans:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[3] = '{digits:16'h0000, lz:1'b1, codes:{4'd0, 4'd0, 4'd0, 4'd0},
                ans:{4'b1111, 4'b1111, 4'b1111, 4'b1110}};
    vecs[4] = '{digits:16'h0500, lz:1'b1, codes:{4'd0, 4'd5, 4'd0, 4'd0},
                ans:{4'b1111, 4'b1011, 4'b1101, 4'b1110}};

    rst       = 1'b1;
    digits_in = '0;
    load      = 1'b0;
    lz_en     = 1'b0;
    step(3);
    check("reset", 4'b1111, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);
    check("first_blank", 4'b1111, 4'd0, 1'b0, 1'b0);

    // Full-frame checks: two blank cycles then six lit cycles per slot.
    for (int v = 0; v < 5; v++) begin
      lz_en = vecs[v].lz;
      load_and_sync(vecs[v].digits);
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 8; c++) begin
          check($sformatf("vec%0d_slot%0d_cyc%0d", v, s, c),
                (c < 2) ? 4'b1111 : vecs[v].ans[s], vecs[v].codes[s],
                (s == 0 && c == 0), 1'b0);
          step(1);
        end
      end
    end

    // Mid-frame load must not disturb the frame in progress.
    lz_en = 1'b0;
    load_and_sync(16'h1234);
    step(16);
    do_load(16'h8765);
    step(2);
    check("midload_slot2", 4'b1011, 4'd2, 1'b0, 1'b0);
    step(8);
    check("midload_slot3", 4'b0111, 4'd1, 1'b0, 1'b0);
    step(5);
    check("midload_newframe", 4'b1111, 4'd5, 1'b1, 1'b0);
    step(3);
    check("midload_slot0", 4'b1110, 4'd5, 1'b0, 1'b0);
    step(8);
    check("midload_slot1", 4'b1101, 4'd6, 1'b0, 1'b0);

    // Invalid code in digit 1 is blanked and flagged stickily.
    load_and_sync(16'h00C3);
    check("err_slot0", 4'b1111, 4'd3, 1'b1, 1'b0);
    step(8);
    check("err_slot1_blank", 4'b1111, 4'd0, 1'b0, 1'b1);
    step(3);
    check("err_slot1_show", 4'b1111, 4'd0, 1'b0, 1'b1);
    load_and_sync(16'h1234);
    check("err_sticky", 4'b1111, 4'd4, 1'b1, 1'b1);
    step(3);
    check("err_sticky_show", 4'b1110, 4'd4, 1'b0, 1'b1);

    // Reset during SHOW of slot 2.
    step(16);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midreset", 4'b1111, 4'd0, 1'b0, 1'b0);
    step(2);
    check("midreset_slot0_show", 4'b1110, 4'd0, 1'b0, 1'b0);
    step(29);
    check("period_before", 4'b0111, 4'd0, 1'b0, 1'b0);
    step(1);
    check("period_wrap", 4'b1111, 4'd0, 1'b1, 1'b0);

    // Back-to-back loads, the second landing on the wrap edge.
    step(30);
    do_load(16'h1119);
    do_load(16'h2226);
    check("wrapload_first", 4'b1111, 4'd9, 1'b1, 1'b0);
    step(32);
    check("wrapload_second", 4'b1111, 4'd6, 1'b1, 1'b0);
    step(11);
    check("wrapload_second_slot1", 4'b1101, 4'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
